// File: rtl/mult_pkg.sv
// Shared definitions for the shared-multiplier scheduler.
//   OP_W / PROD_W : operand and product widths of the multiplier core
//   op_ent_t      : stage-1 pipe entry (valid, requester tag, operands)
//   prod_ent_t    : product pipe entry (valid, requester tag, product)
//   booth_mul     : combinational 16x16 signed radix-4 Booth multiplier core
package mult_pkg;

  localparam int OP_W        = 16;
  localparam int PROD_W      = 32;
  // Wide enough to tag the 8-requester maximum.
  localparam int TAG_FIELD_W = 3;

  typedef struct packed {
    logic                     valid;
    logic [TAG_FIELD_W-1:0]   tag;
    logic signed [OP_W-1:0]   a;
    logic signed [OP_W-1:0]   b;
  } op_ent_t;

  typedef struct packed {
    logic                     valid;
    logic [TAG_FIELD_W-1:0]   tag;
    logic signed [PROD_W-1:0] p;
  } prod_ent_t;

  // Radix-4 Booth recoding of b: each overlapping 3-bit group selects
  // 0, +-a or +-2a; the eight partial products are summed mod 2**32,
  // which gives the exact two's-complement product (no saturation).
  function automatic logic signed [PROD_W-1:0] booth_mul(
    input logic signed [OP_W-1:0] a,
    input logic signed [OP_W-1:0] b
  );
    logic [OP_W:0]             bx;
    logic signed [PROD_W-1:0]  ax;
    logic signed [PROD_W-1:0]  pp;
    logic signed [PROD_W-1:0]  acc;
    logic [2:0]                grp;
    bx  = {b, 1'b0};
    ax  = {{(PROD_W-OP_W){a[OP_W-1]}}, a};
    acc = '0;
    for (int i = 0; i < OP_W/2; i++) begin
      grp = bx[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = ax;
        3'b011:         pp = ax <<< 1;
        3'b100:         pp = -(ax <<< 1);
        3'b101, 3'b110: pp = -ax;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2*i));
    end
    return acc;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own rotating priority pointer.
//   sys_clk, sys_rst_n : clock, async active-low reset (pointer -> 0)
//   req                : eligible requesters
//   gnt                : one-hot grant (or zero when nothing is eligible)
//   gnt_vld, gnt_idx   : grant present / encoded winner
// Winner is the first set request scanning ptr, ptr+1, ... mod NREQ.
// After a grant the pointer moves to winner+1; otherwise it holds.
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [2*NREQ-1:0] req2;
  logic [NREQ-1:0]   rot;
  logic [IDX_W-1:0]  off;
  logic [IDX_W:0]    sum;

  // Rotate the request vector so bit 0 is the pointer position, pick the
  // lowest set bit, then rotate the offset back.
  always_comb begin
    req2 = {req, req};
    rot  = req2[ptr_q +: NREQ];
    off  = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
    gnt_vld = |rot;
    gnt_idx = sum[IDX_W-1:0];
    gnt     = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
    ptr_d   = ptr_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == IDX_W'(NREQ-1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mult16_share_sched.sv
// Round-robin scheduler sharing one combinational 16x16 signed multiplier
// between NREQ requesters, with a 1-deep result buffer per requester.
//   sys_clk, sys_rst_n   : clock, async active-low reset
//   req_valid/req_ready  : per-requester operand handshake (ready = grant)
//   req_a, req_b         : packed signed operands, 16 bits per requester
//   res_valid/res_ready  : per-requester result handshake
//   res_p                : packed signed products, 32 bits per requester
//   busy                 : any op in the pipe or any result buffered
// Optional (macro MULT_SCHED_PERF_EN):
//   perf_grants          : saturating 16-bit grant counter per requester
//   perf_idle            : saturating count of cycles with requests but no grant
// Latency accept->result buffer is PIPE_STAGES edges counting the accept.
module mult16_share_sched
  import mult_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 3
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  output logic [NREQ-1:0]        res_valid,
  input  logic [NREQ-1:0]        res_ready,
  output logic [NREQ*PROD_W-1:0] res_p,
  output logic                   busy
`ifdef MULT_SCHED_PERF_EN
  ,
  output logic [NREQ*16-1:0]     perf_grants,
  output logic [15:0]            perf_idle
`endif
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]          outstanding_q, outstanding_d;
  logic [NREQ-1:0]          res_valid_q, res_valid_d;
  logic [PROD_W-1:0]        res_p_q [NREQ];
  logic [PROD_W-1:0]        res_p_d [NREQ];
  logic [NREQ-1:0]          consume;
  logic [NREQ-1:0]          eligible;
  logic [NREQ-1:0]          gnt;
  logic                     gnt_vld;
  logic [IDX_W-1:0]         gnt_idx;
  logic signed [OP_W-1:0]   sel_a, sel_b;
  logic                     wr_vld;
  logic [TAG_W-1:0]         wr_tag;
  logic signed [PROD_W-1:0] wr_p;
  logic [NREQ-1:0]          wr_hit;
  logic                     pipe_busy;

  // A consume this cycle frees the slot immediately so the same requester
  // can be re-granted on the same edge. Grants are suppressed while reset
  // is asserted so req_ready stays low during reset.
  assign consume  = res_valid_q & res_ready;
  assign eligible = req_valid & ~(outstanding_q & ~consume) & {NREQ{sys_rst_n}};

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (eligible),
    .gnt       (gnt),
    .gnt_vld   (gnt_vld),
    .gnt_idx   (gnt_idx)
  );

  assign req_ready = gnt;

  // One-hot AND-OR operand mux.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*OP_W +: OP_W];
        sel_b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  generate
    if (PIPE_STAGES == 1) begin : g_no_pipe
      // Core sits directly between the operand mux and the result buffer.
      assign wr_vld    = gnt_vld;
      assign wr_tag    = TAG_W'(gnt_idx);
      assign wr_p      = booth_mul(sel_a, sel_b);
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      op_ent_t                  op_q, op_d;
      logic signed [PROD_W-1:0] core_p;

      always_comb begin
        op_d       = op_q;
        op_d.valid = gnt_vld;
        if (gnt_vld) begin
          op_d.tag = TAG_FIELD_W'(gnt_idx);
          op_d.a   = sel_a;
          op_d.b   = sel_b;
        end
      end

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) op_q <= '0;
        else            op_q <= op_d;
      end

      assign core_p = booth_mul(op_q.a, op_q.b);

      if (PIPE_STAGES == 2) begin : g_direct
        assign wr_vld    = op_q.valid;
        assign wr_tag    = TAG_W'(op_q.tag);
        assign wr_p      = core_p;
        assign pipe_busy = op_q.valid;
      end else begin : g_prod
        localparam int NPR = PIPE_STAGES - 2;
        prod_ent_t       prod_q [NPR];
        prod_ent_t       prod_d [NPR];
        logic [NPR-1:0]  prod_vld;

        always_comb begin
          prod_d[0].valid = op_q.valid;
          prod_d[0].tag   = op_q.tag;
          prod_d[0].p     = core_p;
          for (int s = 1; s < NPR; s++) prod_d[s] = prod_q[s-1];
          for (int s = 0; s < NPR; s++) prod_vld[s] = prod_q[s].valid;
        end

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
          if (!sys_rst_n) begin
            for (int s = 0; s < NPR; s++) prod_q[s] <= '0;
          end else begin
            for (int s = 0; s < NPR; s++) prod_q[s] <= prod_d[s];
          end
        end

        assign wr_vld    = prod_q[NPR-1].valid;
        assign wr_tag    = TAG_W'(prod_q[NPR-1].tag);
        assign wr_p      = prod_q[NPR-1].p;
        assign pipe_busy = op_q.valid | (|prod_vld);
      end
    end
  endgenerate

  // A write and a consume never target the same slot in one cycle: the
  // slot is outstanding, so nothing new can be in flight for it while full.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      wr_hit[i]        = wr_vld && (wr_tag == TAG_W'(i));
      res_valid_d[i]   = (res_valid_q[i] & ~res_ready[i]) | wr_hit[i];
      res_p_d[i]       = wr_hit[i] ? wr_p : res_p_q[i];
      outstanding_d[i] = (outstanding_q[i] & ~consume[i]) | gnt[i];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      outstanding_q <= '0;
      res_valid_q   <= '0;
      for (int i = 0; i < NREQ; i++) res_p_q[i] <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      res_valid_q   <= res_valid_d;
      for (int i = 0; i < NREQ; i++) res_p_q[i] <= res_p_d[i];
    end
  end

  always_comb begin
    res_p = '0;
    for (int i = 0; i < NREQ; i++) res_p[i*PROD_W +: PROD_W] = res_p_q[i];
  end

  assign res_valid = res_valid_q;
  assign busy      = pipe_busy | (|res_valid_q);

`ifdef MULT_SCHED_PERF_EN
  logic [15:0] perf_grant_q [NREQ];
  logic [15:0] perf_grant_d [NREQ];
  logic [15:0] perf_idle_q, perf_idle_d;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      perf_grant_d[i] = perf_grant_q[i];
      if (gnt[i] && (perf_grant_q[i] != 16'hFFFF)) perf_grant_d[i] = perf_grant_q[i] + 16'd1;
    end
    perf_idle_d = perf_idle_q;
    if ((|req_valid) && !gnt_vld && (perf_idle_q != 16'hFFFF)) perf_idle_d = perf_idle_q + 16'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NREQ; i++) perf_grant_q[i] <= '0;
      perf_idle_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) perf_grant_q[i] <= perf_grant_d[i];
      perf_idle_q <= perf_idle_d;
    end
  end

  always_comb begin
    perf_grants = '0;
    for (int i = 0; i < NREQ; i++) perf_grants[i*16 +: 16] = perf_grant_q[i];
  end
  assign perf_idle = perf_idle_q;
`endif

endmodule

// File: tb/tb_mult16_share_sched.sv
module tb_mult16_share_sched;

  localparam int NREQ = 2;
  localparam int PS   = 2;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*16-1:0]   req_a, req_b;
  logic [NREQ-1:0]      res_valid;
  logic [NREQ-1:0]      res_ready;
  logic [NREQ*32-1:0]   res_p;
  logic                 busy;
`ifdef MULT_SCHED_PERF_EN
  logic [NREQ*16-1:0]   perf_grants;
  logic [15:0]          perf_idle;
`endif

  mult16_share_sched #(.NREQ(NREQ), .PIPE_STAGES(PS), .TAG_W(3)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_p       (res_p),
    .busy        (busy)
`ifdef MULT_SCHED_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_idle   (perf_idle)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural reference: per-requester flags, one in-flight op each.
  bit          m_out  [NREQ];
  bit          m_resv [NREQ];
  logic [31:0] m_resp [NREQ];
  bit          m_fl   [NREQ];
  int          m_due  [NREQ];
  logic [31:0] m_flp  [NREQ];
  int          m_ptr;
  int          cyc;
  int          wait_cnt [NREQ];
  logic [NREQ-1:0] dut_rdy;

  typedef struct {
    int          req;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int x, y;
    x = $signed(a);
    y = $signed(b);
    return 32'(x * y);
  endfunction

  function automatic logic [15:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_out[i] = 0; m_resv[i] = 0; m_resp[i] = '0; m_fl[i] = 0;
      m_due[i] = 0; m_flp[i] = '0; wait_cnt[i] = 0;
    end
    m_ptr = 0;
    cyc   = 0;
  endtask

  task automatic set_op(input int r, input logic [15:0] a, input logic [15:0] b);
    req_a[16*r +: 16] = a;
    req_b[16*r +: 16] = b;
  endtask

  // Called at posedge+1 with this cycle's inputs already driven; checks the
  // DUT against the model, advances the model across the next edge, and
  // returns at the following posedge+1.
  task automatic do_cycle();
    int win;
    bit cons [NREQ];
    bit elig [NREQ];
    logic [NREQ-1:0] exp_rdy, exp_resv;
    bit any_fl;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      cons[i] = m_resv[i] && res_ready[i];
      elig[i] = req_valid[i] && !(m_out[i] && !cons[i]);
    end
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (win < 0 && elig[j]) win = j;
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    any_fl = 0;
    for (int i = 0; i < NREQ; i++) begin
      exp_resv[i] = m_resv[i];
      any_fl = any_fl | m_fl[i] | m_resv[i];
    end
    dut_rdy = req_ready;
    chk("req_ready", req_ready, exp_rdy);
    chk("res_valid", res_valid, exp_resv);
    for (int i = 0; i < NREQ; i++) chk($sformatf("res_p[%0d]", i), res_p[32*i +: 32], m_resp[i]);
    chk("busy", busy, any_fl);
    for (int i = 0; i < NREQ; i++) begin
      if (elig[i] && win != i) wait_cnt[i]++;
      else                     wait_cnt[i] = 0;
      chk($sformatf("wait_bound[%0d]", i), (wait_cnt[i] <= NREQ-1), 1'b1);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (cons[i]) begin m_resv[i] = 0; m_out[i] = 0; end
    end
    if (win >= 0) begin
      m_out[win] = 1;
      m_fl[win]  = 1;
      m_due[win] = cyc + PS - 1;
      m_flp[win] = ref_mul(req_a[16*win +: 16], req_b[16*win +: 16]);
      m_ptr      = (win + 1) % NREQ;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (m_fl[i] && m_due[i] == cyc) begin
        m_fl[i] = 0; m_resv[i] = 1; m_resp[i] = m_flp[i];
      end
    end
    cyc++;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    res_ready = '1;
    repeat (PS + 2) do_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, gcnt1, t;

    vecs[0] = '{0, 16'd3,     16'd5,     32'd15};
    vecs[1] = '{1, 16'hFFF9,  16'd9,     32'hFFFFFFC1};
    vecs[2] = '{0, 16'h8000,  16'h8000,  32'h40000000};
    vecs[3] = '{1, 16'h7FFF,  16'h8000,  32'hC0008000};
    vecs[4] = '{0, 16'h7FFF,  16'h7FFF,  32'h3FFF0001};
    vecs[5] = '{1, 16'hFFFF,  16'hFFFF,  32'h00000001};
    vecs[6] = '{0, 16'h0000,  16'h8000,  32'h00000000};
    vecs[7] = '{1, 16'h1234,  16'hFF00,  32'hFFEDCC00};

    // Reset with all requests asserted.
    sys_rst_n = 1'b0;
    req_valid = '1;
    res_ready = '0;
    req_a = '0; req_b = '0;
    set_op(0, 16'd2, 16'd4);
    set_op(1, 16'd6, 16'd7);
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_res_valid", res_valid, '0);
    chk("rst_res_p", res_p, '0);
    chk("rst_busy", busy, 1'b0);
    sys_rst_n = 1'b1;
    do_cycle();
    chk("first_grant", dut_rdy, 2'b01);
    drain();

    // Single op on requester 0, held until consumed.
    set_op(0, 16'd3, 16'd5);
    req_valid = 2'b01;
    res_ready = 2'b00;
    do_cycle();
    chk("single_grant", dut_rdy, 2'b01);
    do_cycle();
    chk("single_valid", res_valid[0], 1'b1);
    chk("single_p", res_p[31:0], 32'd15);
    do_cycle();
    chk("single_hold_ready", dut_rdy[0], 1'b0);
    res_ready = 2'b01;
    do_cycle();
    chk("single_regrant", dut_rdy[0], 1'b1);
    drain();

    // Table of signed corner products.
    foreach (vecs[v]) begin
      set_op(vecs[v].req, vecs[v].a, vecs[v].b);
      req_valid = '0;
      req_valid[vecs[v].req] = 1'b1;
      res_ready = '0;
      do_cycle();
      req_valid = '0;
      t = 0;
      while (t < 10 && !res_valid[vecs[v].req]) begin
        do_cycle();
        t++;
      end
      chk($sformatf("vec%0d_valid", v), res_valid[vecs[v].req], 1'b1);
      chk($sformatf("vec%0d_p", v), res_p[32*vecs[v].req +: 32], vecs[v].p);
      drain();
    end

    // Fairness: both requesting, results consumed at once.
    req_valid = 2'b11;
    res_ready = 2'b11;
    first = m_ptr;
    for (int k = 0; k < 8; k++) begin
      logic [NREQ-1:0] e;
      set_op(0, pick_op(), pick_op());
      set_op(1, pick_op(), pick_op());
      e = '0;
      e[(first + k) % NREQ] = 1'b1;
      do_cycle();
      chk($sformatf("fair_grant%0d", k), dut_rdy, e);
    end
    drain();

    // Backpressure on requester 1.
    req_valid = 2'b11;
    res_ready = 2'b01;
    gcnt1 = 0;
    for (int k = 0; k < 12; k++) begin
      do_cycle();
      if (dut_rdy[1]) gcnt1++;
    end
    chk("bp_req1_grants", gcnt1, 1);
    req_valid = 2'b10;
    res_ready = 2'b11;
    do_cycle();
    chk("bp_regrant_on_consume", dut_rdy, 2'b10);
    drain();

    // Reset one cycle after accept drops the op.
    set_op(0, 16'd100, 16'hFFFE);
    req_valid = 2'b01;
    res_ready = 2'b00;
    do_cycle();
    req_valid = 2'b00;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_res_valid", res_valid, '0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    model_reset();
    repeat (4) do_cycle();
    chk("midrst_no_result", res_valid, '0);
    set_op(0, 16'hFFFB, 16'd6);
    req_valid = 2'b01;
    do_cycle();
    req_valid = 2'b00;
    do_cycle();
    chk("midrst_next_valid", res_valid[0], 1'b1);
    chk("midrst_next_p", res_p[31:0], 32'hFFFFFFE2);
    drain();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      req_valid = NREQ'($urandom_range(0, 3));
      for (int i = 0; i < NREQ; i++) begin
        res_ready[i] = ($urandom_range(0, 3) != 0);
        set_op(i, pick_op(), pick_op());
      end
      do_cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
